// File: rtl/ram_req_responder.sv
// ram_req_responder: memory-side responder for a valid/ready request interface.
// Services writes and reads from an internal 2^A x D array and returns one
// response per accepted request. The array is zero-filled after every reset
// (INIT) before any request is accepted.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   req_valid  initiator presents a request
//   req_ready  responder can accept a request this cycle (combinational)
//   req_we     1 = write, 0 = read
//   req_addr   word address
//   req_wdata  write data (ignored for reads)
//   rsp_valid  response held on rsp_* outputs
//   rsp_ready  initiator consumes the response
//   rsp_we     type of the request this response answers
//   rsp_rdata  read data, or echo of the written data
//   init_done  zero-fill complete; high while in RUN
module ram_req_responder #(
  parameter int unsigned D = 8,
  parameter int unsigned A = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_we,
  input  logic [A-1:0] req_addr,
  input  logic [D-1:0] req_wdata,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_we,
  output logic [D-1:0] rsp_rdata,
  output logic         init_done
);

  localparam int unsigned DEPTH = 1 << A;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t         state;
  state_t         state_next;
  logic [A-1:0]   cnt;
  logic [D-1:0]   mem [DEPTH];
  logic           accept;

  assign init_done = (state == RUN);
  assign req_ready = init_done & (~rsp_valid | rsp_ready);
  // req_ready is 0 in INIT and during a held response, so X on req_* then
  // cannot reach the memory or response registers.
  assign accept    = req_valid & req_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= INIT;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      INIT:    if (cnt == '1) state_next = RUN;
      RUN:     state_next = RUN;
      default: state_next = INIT;
    endcase
  end

  // Fill counter saturates at the last address so it never wraps inside INIT.
  always_ff @(posedge clk) begin
    if (rst)                             cnt <= '0;
    else if (state == INIT && cnt != '1) cnt <= cnt + A'(1);
  end

  // Storage: no reset of its own; the reset edge itself writes nothing.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == INIT)          mem[cnt]      <= '0;
      else if (accept && req_we)  mem[req_addr] <= req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_we    <= 1'b0;
      rsp_rdata <= '0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_we    <= req_we;
      rsp_rdata <= req_we ? req_wdata : mem[req_addr];
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule
